mem_rr_arbiter: RTL

Round-robin arbiter that shares one memory/IO slave port between `N_CORES` PicoRV32 native memory interfaces (valid/ready). It replaces the free-running slot counter in the SoC with a request-driven scheduler. Idle cores consume no slots, each transfer is protected by a bounded-wait timeout, and every core is guaranteed service within `N_CORES` transfers. It sits between the core array and the RAM/LED/UART decode logic.

---
 rtl/mem_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-style memory slave port between
// N_CORES requesters. Request-driven: idle cores consume no slots, each
// transfer is bounded by an optional wait timeout, and the core that just
// finished has the lowest priority in the next arbitration.
module mem_rr_arbiter #(
  parameter int N_CORES  = 4,
  parameter int IDX_BITS = $clog2(N_CORES),
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CORES-1:0]      req_valid,
  input  logic [32*N_CORES-1:0]   req_addr,
  input  logic [32*N_CORES-1:0]   req_wdata,
  input  logic [4*N_CORES-1:0]    req_wstrb,
  output logic [N_CORES-1:0]      req_ready,
  output logic [32*N_CORES-1:0]   req_rdata,
  output logic                    mem_valid,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wstrb,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata,
  output logic [IDX_BITS-1:0]     grant_idx,
  output logic                    busy,
  output logic                    timeout_err
);

  // A disabled timeout still needs a legal (unused) one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [IDX_BITS-1:0] last_reg;
  logic [CNT_W-1:0]    wait_reg;
  logic [31:0]         rdata_reg [N_CORES];

  logic [31:0]         lane_addr  [N_CORES];
  logic [31:0]         lane_wdata [N_CORES];
  logic [3:0]          lane_wstrb [N_CORES];

  logic                sel_found;
  logic [IDX_BITS-1:0] sel_idx;
  logic [IDX_BITS-1:0] cand_idx;
  logic                timeout_hit;

  // Split the flat per-core buses into lanes and expose the held read data.
  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_lane
    assign lane_addr[gi]          = req_addr[32*gi +: 32];
    assign lane_wdata[gi]         = req_wdata[32*gi +: 32];
    assign lane_wstrb[gi]         = req_wstrb[4*gi +: 4];
    assign req_rdata[32*gi +: 32] = rdata_reg[gi];
  end

  // Rotating-priority pick: scan from last (lowest priority) downward so the
  // candidate nearest to last+1 is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int k = N_CORES; k >= 1; k--) begin
      cand_idx = IDX_BITS'((int'(last_reg) + k) % N_CORES);
      if (req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_reg == WAIT_LIMIT);

  // Arbitration FSM with all slave-side and requester-side outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= IDX_BITS'(N_CORES - 1);
      wait_reg    <= '0;
      grant_idx   <= '0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      req_ready   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        rdata_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            last_reg  <= sel_idx;
            mem_addr  <= lane_addr[sel_idx];
            mem_wdata <= lane_wdata[sel_idx];
            mem_wstrb <= lane_wstrb[sel_idx];
            wait_reg  <= '0;
            mem_valid <= 1'b1;
            busy      <= 1'b1;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          wait_reg <= wait_reg + CNT_W'(1);
          // A response on the timeout cycle still counts as a real response.
          if (mem_ready) begin
            rdata_reg[grant_idx] <= mem_rdata;
            mem_valid            <= 1'b0;
            req_ready            <= '0;
            req_ready[grant_idx] <= 1'b1;
            state_reg            <= DONE;
          end else if (timeout_hit) begin
            rdata_reg[grant_idx] <= '0;
            mem_valid            <= 1'b0;
            req_ready            <= '0;
            req_ready[grant_idx] <= 1'b1;
            timeout_err          <= 1'b1;
            state_reg            <= DONE;
          end
        end
        DONE: begin
          // The finishing core drops its request on this edge; no arbitration.
          req_ready   <= '0;
          timeout_err <= 1'b0;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
